pc_sequencer: RTL and testbench
===============================

PC_SEQUENCER -- requirements
Module: pc_sequencer

Interface
REQ-001 The block SHALL use one clock and an asynchronous, active-low reset.
REQ-002 The block SHALL provide parameter XLEN, default 32, giving the PC width in bits.
REQ-003 The block SHALL provide parameter RESET_VECTOR, default 0, giving the PC value loaded on reset.
REQ-004 The block SHALL provide parameter TRAP_VECTOR, default 32'h0000_0100, giving the PC value loaded on a trap or misaligned redirect.
REQ-005 The block SHALL provide parameter RAS_DEPTH, default 4, giving the return-address-stack entry count; it must be a power of 2 and at least 2.
REQ-006 The block SHALL have port clk, input, 1 bit: the rising-edge clock.
REQ-007 The block SHALL have port reset, input, 1 bit: asynchronous reset, active when 0.
REQ-008 The block SHALL have port stall, input, 1 bit: hold the PC.
REQ-009 The block SHALL have port trap, input, 1 bit: exception request.
REQ-010 The block SHALL have port redirect_valid, input, 1 bit: a control-flow change this cycle.
REQ-011 The block SHALL have port redirect_kind, input, 2 bits: 00 jump, 01 call, 10 return, 11 treated as jump.
REQ-012 The block SHALL have port redirect_target, input, XLEN bits: the computed target address.
REQ-013 The block SHALL have port pc, output, XLEN bits: the registered current PC.
REQ-014 The block SHALL have port pc_next, output, XLEN bits: the combinational value pc will take at the next edge.
REQ-015 The block SHALL have port misaligned, output, 1 bit: a registered one-cycle pulse.
REQ-016 The block SHALL have port ras_count, output, $clog2(RAS_DEPTH)+1 bits: the number of valid stack entries.

Function
REQ-017 The next PC SHALL be selected in strict priority order:
- trap: TRAP_VECTOR
- redirect_valid: target as defined in REQ-018 to REQ-020
- stall: pc unchanged
- otherwise: pc+4, wrapping modulo 2^XLEN
REQ-018 A jump SHALL load redirect_target and leave the RAS unchanged.
REQ-019 A call SHALL load redirect_target and push pc+4 onto the RAS.
REQ-020 A return SHALL load the popped top entry when ras_count>0, and SHALL load redirect_target with ras_count staying 0 when the RAS is empty.
REQ-021 trap and redirect SHALL override stall, so stall never blocks a redirect.
REQ-022 A redirect whose effective target has bits [1:0] not equal to 0 SHALL load TRAP_VECTOR, assert misaligned for exactly the following cycle, and leave the RAS unchanged (no push or pop).
REQ-023 A push when ras_count==RAS_DEPTH SHALL overwrite the oldest entry, with the circular top pointer wrapping and ras_count saturating at RAS_DEPTH.
REQ-024 A trap SHALL clear ras_count to 0 in the same edge; simultaneous redirect or stall inputs SHALL be ignored.
REQ-025 At most one RAS operation SHALL occur per cycle, and none SHALL occur in a stalled cycle that has no redirect.
REQ-026 pc_next SHALL equal pc at every rising edge once reset is released.
REQ-027 pc SHALL take its new value one cycle after the triggering input (latency 1).

Reset
REQ-028 While reset==0, pc SHALL be RESET_VECTOR, misaligned SHALL be 0, ras_count SHALL be 0, and the RAS pointer SHALL be 0, all set asynchronously.
REQ-029 RAS entry contents SHALL not require reset.
REQ-030 After reset deasserts, the first rising edge SHALL advance pc normally.
REQ-031 A reset asserted mid-operation SHALL discard any pending redirect.

Structure
REQ-032 A shared package pc_pkg SHALL hold the redirect_kind enum (RK_JUMP, RK_CALL, RK_RET, RK_RSVD) and the default vector constants.
REQ-033 The RAS SHALL be implemented as sub-module pc_ras, with push/pop/clear/push_data inputs and top/count outputs, parametrised by XLEN and RAS_DEPTH, on the same clk/reset.
REQ-034 All next-PC selection SHALL be a single combinational block feeding one registered stage.

Verification
REQ-035 Reset sequence: hold reset=0, release, run 3 idle cycles -> pc is 0, then 4, 8, 12; ras_count is 0.
REQ-036 Stall vs redirect: stall=1 for 2 cycles -> pc is held; stall=1 together with a jump to 0x40 -> pc becomes 0x40 next cycle.
REQ-037 Call and return: call to 0x200 issued at pc=0x10 -> pc becomes 0x200 and ras_count becomes 1; return with redirect_target=0x999C -> pc becomes 0x14 and ras_count becomes 0.
REQ-038 RAS overflow and underflow with RAS_DEPTH=4: 5 calls from pcs A..E -> ras_count is 4; 4 returns -> targets are E+4, D+4, C+4, B+4; a 5th return -> redirect_target is used.
REQ-039 Misaligned redirect: jump to 0x102 -> pc becomes 0x100 and misaligned is 1 for one cycle; ras_count is unchanged.
REQ-040 Trap priority: trap, call, and stall asserted in the same cycle with ras_count=3 -> pc becomes 0x100 and ras_count becomes 0.

Source files
------------

// File: rtl/pc_pkg.sv
// Shared types and default vectors for the program-counter sequencer and its return-address stack.
package pc_pkg;

  typedef enum logic [1:0] {
    RK_JUMP = 2'b00,
    RK_CALL = 2'b01,
    RK_RET  = 2'b10,
    RK_RSVD = 2'b11
  } redirect_kind_e;

  localparam logic [31:0] PC_RESET_VECTOR_DEFAULT = 32'h0000_0000;
  localparam logic [31:0] PC_TRAP_VECTOR_DEFAULT  = 32'h0000_0100;

endpackage

// File: rtl/pc_ras.sv
// Circular return-address stack; a push when full overwrites the oldest entry.
module pc_ras #(
  parameter int XLEN      = 32,
  parameter int RAS_DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         push,
  input  logic                         pop,
  input  logic                         clear,
  input  logic [XLEN-1:0]              push_data,
  output logic [XLEN-1:0]              top,
  output logic [$clog2(RAS_DEPTH):0]   count
);

  localparam int PW = $clog2(RAS_DEPTH);
  localparam int CW = PW + 1;

  logic [XLEN-1:0] mem [RAS_DEPTH];
  logic [PW-1:0]   ptr;

  // ptr names the next free slot, so the newest entry sits one below it.
  assign top = mem[ptr - PW'(1)];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ptr   <= '0;
      count <= '0;
    end else if (clear) begin
      ptr   <= '0;
      count <= '0;
    end else if (push) begin
      ptr <= ptr + PW'(1);
      if (count != CW'(RAS_DEPTH)) count <= count + CW'(1);
    end else if (pop && (count != '0)) begin
      ptr   <= ptr - PW'(1);
      count <= count - CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (push && !clear) mem[ptr] <= push_data;
  end

endmodule

// File: rtl/pc_sequencer.sv
// Next-PC selection with trap, redirect (jump/call/return), stall and a return-address stack.
module pc_sequencer
  import pc_pkg::*;
#(
  parameter int              XLEN         = 32,
  parameter logic [XLEN-1:0] RESET_VECTOR = XLEN'(PC_RESET_VECTOR_DEFAULT),
  parameter logic [XLEN-1:0] TRAP_VECTOR  = XLEN'(PC_TRAP_VECTOR_DEFAULT),
  parameter int              RAS_DEPTH    = 4
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        stall,
  input  logic                        trap,
  input  logic                        redirect_valid,
  input  logic [1:0]                  redirect_kind,
  input  logic [XLEN-1:0]             redirect_target,
  output logic [XLEN-1:0]             pc,
  output logic [XLEN-1:0]             pc_next,
  output logic                        misaligned,
  output logic [$clog2(RAS_DEPTH):0]  ras_count
);

  redirect_kind_e  kind;
  logic [XLEN-1:0] pc_plus4;
  logic [XLEN-1:0] ras_top;
  logic [XLEN-1:0] eff_target;
  logic            ras_push;
  logic            ras_pop;
  logic            ras_clear;
  logic            mis_next;

  assign kind     = redirect_kind_e'(redirect_kind);
  assign pc_plus4 = pc + XLEN'(4);

  // An empty stack falls back to the computed target for returns.
  assign eff_target = ((kind == RK_RET) && (ras_count != '0)) ? ras_top : redirect_target;

  always_comb begin
    pc_next   = pc_plus4;
    ras_push  = 1'b0;
    ras_pop   = 1'b0;
    ras_clear = 1'b0;
    mis_next  = 1'b0;
    if (trap) begin
      pc_next   = TRAP_VECTOR;
      ras_clear = 1'b1;
    end else if (redirect_valid) begin
      if (eff_target[1:0] != 2'b00) begin
        pc_next  = TRAP_VECTOR;
        mis_next = 1'b1;
      end else begin
        pc_next  = eff_target;
        ras_push = (kind == RK_CALL);
        ras_pop  = (kind == RK_RET) && (ras_count != '0);
      end
    end else if (stall) begin
      pc_next = pc;
    end
  end

  // Single registered stage for pc and the misaligned pulse.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc         <= RESET_VECTOR;
      misaligned <= 1'b0;
    end else begin
      pc         <= pc_next;
      misaligned <= mis_next;
    end
  end

  pc_ras #(
    .XLEN      (XLEN),
    .RAS_DEPTH (RAS_DEPTH)
  ) u_ras (
    .clk       (clk),
    .reset     (reset),
    .push      (ras_push),
    .pop       (ras_pop),
    .clear     (ras_clear),
    .push_data (pc_plus4),
    .top       (ras_top),
    .count     (ras_count)
  );

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed bench for pc_sequencer: reset, stall/redirect priority, call/return, RAS wrap, misalignment, trap.
module tb_pc_sequencer;

  logic        clk;
  logic        reset;
  logic        stall;
  logic        trap;
  logic        redirect_valid;
  logic [1:0]  redirect_kind;
  logic [31:0] redirect_target;
  logic [31:0] pc;
  logic [31:0] pc_next;
  logic        misaligned;
  logic [2:0]  ras_count;

  int total = 0;
  int bad   = 0;

  pc_sequencer dut (
    .clk             (clk),
    .reset           (reset),
    .stall           (stall),
    .trap            (trap),
    .redirect_valid  (redirect_valid),
    .redirect_kind   (redirect_kind),
    .redirect_target (redirect_target),
    .pc              (pc),
    .pc_next         (pc_next),
    .misaligned      (misaligned),
    .ras_count       (ras_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog expired got=running exp=finished");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic t, input logic rv, input logic [1:0] rk,
                       input logic [31:0] tgt, input logic st);
    trap = t; redirect_valid = rv; redirect_kind = rk; redirect_target = tgt; stall = st;
  endtask

  task automatic idle();
    drive(1'b0, 1'b0, 2'b00, 32'h0, 1'b0);
  endtask

  task automatic test_reset();
    logic [31:0] exp_pc [3];
    exp_pc[0] = 32'h4; exp_pc[1] = 32'h8; exp_pc[2] = 32'hC;
    idle();
    reset = 1'b0;
    step(); step();
    total++; if (pc !== 32'h0) begin bad++; $display("FAIL reset_pc got=%h exp=%h", pc, 32'h0); end
    total++; if (ras_count !== 3'd0) begin bad++; $display("FAIL reset_count got=%0d exp=0", ras_count); end
    total++; if (misaligned !== 1'b0) begin bad++; $display("FAIL reset_mis got=%b exp=0", misaligned); end
    reset = 1'b1;
    total++; if (pc_next !== 32'h4) begin bad++; $display("FAIL reset_pc_next got=%h exp=%h", pc_next, 32'h4); end
    for (int i = 0; i < 3; i++) begin
      step();
      total++; if (pc !== exp_pc[i]) begin bad++; $display("FAIL reset_seq%0d got=%h exp=%h", i, pc, exp_pc[i]); end
    end
    total++; if (ras_count !== 3'd0) begin bad++; $display("FAIL reset_seq_count got=%0d exp=0", ras_count); end
  endtask

  task automatic test_stall();
    drive(1'b0, 1'b0, 2'b00, 32'h0, 1'b1);
    step();
    total++; if (pc !== 32'hC) begin bad++; $display("FAIL stall_hold1 got=%h exp=%h", pc, 32'hC); end
    step();
    total++; if (pc !== 32'hC) begin bad++; $display("FAIL stall_hold2 got=%h exp=%h", pc, 32'hC); end
    drive(1'b0, 1'b1, 2'b00, 32'h40, 1'b1);
    #1;
    total++; if (pc_next !== 32'h40) begin bad++; $display("FAIL stall_jump_next got=%h exp=%h", pc_next, 32'h40); end
    step();
    total++; if (pc !== 32'h40) begin bad++; $display("FAIL stall_jump got=%h exp=%h", pc, 32'h40); end
    idle();
  endtask

  task automatic test_call_return();
    drive(1'b0, 1'b1, 2'b00, 32'h10, 1'b0);
    step();
    total++; if (pc !== 32'h10) begin bad++; $display("FAIL cr_setup got=%h exp=%h", pc, 32'h10); end
    drive(1'b0, 1'b1, 2'b01, 32'h200, 1'b0);
    step();
    total++; if (pc !== 32'h200) begin bad++; $display("FAIL cr_call_pc got=%h exp=%h", pc, 32'h200); end
    total++; if (ras_count !== 3'd1) begin bad++; $display("FAIL cr_call_count got=%0d exp=1", ras_count); end
    drive(1'b0, 1'b1, 2'b10, 32'h999C, 1'b0);
    step();
    total++; if (pc !== 32'h14) begin bad++; $display("FAIL cr_ret_pc got=%h exp=%h", pc, 32'h14); end
    total++; if (ras_count !== 3'd0) begin bad++; $display("FAIL cr_ret_count got=%0d exp=0", ras_count); end
    // Reserved kind behaves as a plain jump.
    drive(1'b0, 1'b1, 2'b11, 32'h600, 1'b0);
    step();
    total++; if (pc !== 32'h600) begin bad++; $display("FAIL cr_rsvd_pc got=%h exp=%h", pc, 32'h600); end
    total++; if (ras_count !== 3'd0) begin bad++; $display("FAIL cr_rsvd_count got=%0d exp=0", ras_count); end
    idle();
  endtask

  task automatic test_ras_wrap();
    logic [31:0] call_tgt [5];
    logic [2:0]  call_cnt [5];
    logic [31:0] ret_pc   [4];
    call_tgt[0] = 32'h2000; call_tgt[1] = 32'h3000; call_tgt[2] = 32'h4000;
    call_tgt[3] = 32'h5000; call_tgt[4] = 32'h6000;
    call_cnt[0] = 3'd1; call_cnt[1] = 3'd2; call_cnt[2] = 3'd3; call_cnt[3] = 3'd4; call_cnt[4] = 3'd4;
    ret_pc[0] = 32'h5004; ret_pc[1] = 32'h4004; ret_pc[2] = 32'h3004; ret_pc[3] = 32'h2004;
    drive(1'b0, 1'b1, 2'b00, 32'h1000, 1'b0);
    step();
    for (int i = 0; i < 5; i++) begin
      drive(1'b0, 1'b1, 2'b01, call_tgt[i], 1'b0);
      step();
      total++; if (pc !== call_tgt[i]) begin bad++; $display("FAIL wrap_call%0d_pc got=%h exp=%h", i, pc, call_tgt[i]); end
      total++; if (ras_count !== call_cnt[i]) begin bad++; $display("FAIL wrap_call%0d_count got=%0d exp=%0d", i, ras_count, call_cnt[i]); end
    end
    for (int i = 0; i < 4; i++) begin
      drive(1'b0, 1'b1, 2'b10, 32'h8888, 1'b0);
      step();
      total++; if (pc !== ret_pc[i]) begin bad++; $display("FAIL wrap_ret%0d_pc got=%h exp=%h", i, pc, ret_pc[i]); end
      total++; if (ras_count !== 3'(3 - i)) begin bad++; $display("FAIL wrap_ret%0d_count got=%0d exp=%0d", i, ras_count, 3 - i); end
    end
    drive(1'b0, 1'b1, 2'b10, 32'h7000, 1'b0);
    step();
    total++; if (pc !== 32'h7000) begin bad++; $display("FAIL wrap_empty_pc got=%h exp=%h", pc, 32'h7000); end
    total++; if (ras_count !== 3'd0) begin bad++; $display("FAIL wrap_empty_count got=%0d exp=0", ras_count); end
    idle();
  endtask

  task automatic test_misaligned();
    drive(1'b0, 1'b1, 2'b01, 32'h8000, 1'b0);
    step();
    total++; if (ras_count !== 3'd1) begin bad++; $display("FAIL mis_setup_count got=%0d exp=1", ras_count); end
    drive(1'b0, 1'b1, 2'b00, 32'h102, 1'b0);
    step();
    total++; if (pc !== 32'h100) begin bad++; $display("FAIL mis_jump_pc got=%h exp=%h", pc, 32'h100); end
    total++; if (misaligned !== 1'b1) begin bad++; $display("FAIL mis_jump_flag got=%b exp=1", misaligned); end
    total++; if (ras_count !== 3'd1) begin bad++; $display("FAIL mis_jump_count got=%0d exp=1", ras_count); end
    idle();
    step();
    total++; if (misaligned !== 1'b0) begin bad++; $display("FAIL mis_pulse_end got=%b exp=0", misaligned); end
    total++; if (pc !== 32'h104) begin bad++; $display("FAIL mis_after_pc got=%h exp=%h", pc, 32'h104); end
    drive(1'b0, 1'b1, 2'b01, 32'h203, 1'b0);
    step();
    total++; if (pc !== 32'h100) begin bad++; $display("FAIL mis_call_pc got=%h exp=%h", pc, 32'h100); end
    total++; if (misaligned !== 1'b1) begin bad++; $display("FAIL mis_call_flag got=%b exp=1", misaligned); end
    total++; if (ras_count !== 3'd1) begin bad++; $display("FAIL mis_call_count got=%0d exp=1", ras_count); end
    idle();
  endtask

  task automatic test_trap();
    drive(1'b0, 1'b1, 2'b01, 32'h300, 1'b0);
    step();
    drive(1'b0, 1'b1, 2'b01, 32'h400, 1'b0);
    step();
    total++; if (ras_count !== 3'd3) begin bad++; $display("FAIL trap_setup_count got=%0d exp=3", ras_count); end
    drive(1'b1, 1'b1, 2'b01, 32'h800, 1'b1);
    step();
    total++; if (pc !== 32'h100) begin bad++; $display("FAIL trap_pc got=%h exp=%h", pc, 32'h100); end
    total++; if (ras_count !== 3'd0) begin bad++; $display("FAIL trap_count got=%0d exp=0", ras_count); end
    total++; if (misaligned !== 1'b0) begin bad++; $display("FAIL trap_mis got=%b exp=0", misaligned); end
    idle();
    step();
    total++; if (pc !== 32'h104) begin bad++; $display("FAIL trap_after_pc got=%h exp=%h", pc, 32'h104); end
  endtask

  task automatic test_reset_midop();
    drive(1'b0, 1'b1, 2'b01, 32'h500, 1'b0);
    #2;
    reset = 1'b0;
    #1;
    total++; if (pc !== 32'h0) begin bad++; $display("FAIL midrst_async_pc got=%h exp=%h", pc, 32'h0); end
    step();
    total++; if (pc !== 32'h0) begin bad++; $display("FAIL midrst_held_pc got=%h exp=%h", pc, 32'h0); end
    total++; if (ras_count !== 3'd0) begin bad++; $display("FAIL midrst_count got=%0d exp=0", ras_count); end
    idle();
    reset = 1'b1;
    step();
    total++; if (pc !== 32'h4) begin bad++; $display("FAIL midrst_resume_pc got=%h exp=%h", pc, 32'h4); end
  endtask

  initial begin
    reset = 1'b0;
    idle();
    test_reset();
    test_stall();
    test_call_return();
    test_ras_wrap();
    test_misaligned();
    test_trap();
    test_reset_midop();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
